div_seq: RTL and testbench

Multi-cycle divider sequencer for the execute stage. It accepts a DIV/DIVU operand pair, runs a 32-iteration restoring division, and returns a 64-bit {remainder, quotient} result for HI/LO writeback. While a division is in flight it raises a stall request to the pipeline controller, so PC, IF, ID and EX hold and MEM/WB keep draining. It is the source of the execute-stage stall request.

---
 rtl/div_seq_pkg.sv | 25 ++
 rtl/div_seq.sv | 133 +++++++++++++
 tb/tb_div_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared constants for the execute-stage divider: state encodings, handshake
// levels and the operand magnitude/negation helpers.
package div_seq_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic RST_ACTIVE           = 1'b0;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [DIV_W-1:0] cond_neg(input logic neg, input logic [DIV_W-1:0] v);
        return neg ? (~v + {{(DIV_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU with HI/LO result and a
// combinational execute-stage stall request.
//
// state       | meaning
// ------------+-------------------------------------------------------
// DIV_FREE    | idle, waiting for start_i with annul_i low
// DIV_BY_ZERO | divisor was zero, result forced to 0 next edge
// DIV_ON      | 32 restoring iterations, then sign fixup
// DIV_END     | result valid, held while start_i stays high
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    div_state_e         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH:0]   work_q, work_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               is_signed_q, is_signed_d;
    logic               dvd_neg_q, dvd_neg_d;
    logic               dvs_neg_q, dvs_neg_d;
    logic [2*WIDTH-1:0] result_d;
    logic               ready_d;
    logic [WIDTH:0]     trial;
    logic               accept;

    assign trial  = {1'b0, work_q[2*WIDTH-1:WIDTH]} - {1'b0, dvs_q};
    assign accept = (start_i == DIV_START) && !annul_i;

    assign stallreq_o = (start_i == DIV_START) & ~annul_i & (state_q != DIV_END);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        dvs_d       = dvs_q;
        is_signed_d = is_signed_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        result_d    = result_o;
        ready_d     = ready_o;

        unique case (state_q)
            DIV_FREE: begin
                ready_d  = DIV_RESULT_NOT_READY;
                result_d = '0;
                if (accept) begin
                    is_signed_d = signed_div_i;
                    dvd_neg_d   = signed_div_i & opdata1_i[WIDTH-1];
                    dvs_neg_d   = signed_div_i & opdata2_i[WIDTH-1];
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        dvs_d   = cond_neg(signed_div_i & opdata2_i[WIDTH-1], opdata2_i);
                        work_d  = {{WIDTH{1'b0}},
                                   cond_neg(signed_div_i & opdata1_i[WIDTH-1], opdata1_i), 1'b0};
                        cnt_d   = '0;
                        state_d = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
                state_d  = DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = DIV_FREE;
                end else if (cnt_q != 6'd32) begin
                    // Restoring step: keep the shifted partial remainder when the trial borrows.
                    if (trial[WIDTH])
                        work_d = {work_q[2*WIDTH-1:0], 1'b0};
                    else
                        work_d = {trial[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {cond_neg(is_signed_q & dvd_neg_q, work_q[2*WIDTH:WIDTH+1]),
                                cond_neg(is_signed_q & (dvd_neg_q ^ dvs_neg_q), work_q[WIDTH-1:0])};
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP || annul_i) begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                    state_d  = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q     <= DIV_FREE;
            cnt_q       <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            is_signed_q <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            result_o    <= '0;
            ready_o     <= DIV_RESULT_NOT_READY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            dvs_q       <= dvs_d;
            is_signed_q <= is_signed_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            result_o    <= result_d;
            ready_o     <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: latency-level reference model checked on
// every falling edge, plus directed divides with literal expected results.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int tests = 0;
    int fails = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference quotient/remainder from plain arithmetic.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = int'(a);
            sb = int'(b);
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Model: only the observable contract (latency, hold, flush), not the FSM.
    logic        m_ready;
    logic [63:0] m_res;
    logic [63:0] m_pending;
    int          m_left;
    logic        m_div0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready = 1'b0;
            m_res   = 64'd0;
            m_left  = 0;
            m_div0  = 1'b0;
        end else if (m_ready) begin
            if (!start_i || annul_i) begin
                m_ready = 1'b0;
                m_res   = 64'd0;
            end
        end else if (m_left > 0) begin
            if (annul_i && !m_div0) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_ready = 1'b1;
                    m_res   = m_pending;
                end
            end
        end else if (start_i && !annul_i) begin
            m_div0    = (opdata2_i == 32'd0);
            m_left    = m_div0 ? 1 : 33;
            m_pending = ref_div(signed_div_i, opdata1_i, opdata2_i);
        end
    end

    always @(negedge clk) begin
        check("ready_o", {63'd0, ready_o}, {63'd0, m_ready});
        check("result_o", result_o, m_res);
        check("stallreq_o", {63'd0, stallreq_o}, {63'd0, start_i & ~annul_i & ~m_ready});
    end

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_lat, input int hold);
        int n;
        int stalls;
        check("model_pin", ref_div(s, a, b), exp);
        @(posedge clk);
        #1;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1;
        stalls = int'(stallreq_o);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_o) break;
            stalls += int'(stallreq_o);
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("stall_cycles", 64'(stalls), 64'(exp_lat));
        check("result", result_o, exp);
        check("stall_in_end", {63'd0, stallreq_o}, 64'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_ready", {63'd0, ready_o}, 64'd1);
            check("hold_result", result_o, exp);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("release_ready", {63'd0, ready_o}, 64'd0);
        check("release_result", result_o, 64'd0);
        @(posedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 34, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 34, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 34, 0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 34, 0);
        run_div(1'b0, 32'h8000_0000, 32'd3, {32'd2, 32'h2AAA_AAAA}, 34, 0);
        run_div(1'b0, 32'd1234, 32'd0, 64'd0, 2, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0, 64'd0, 2, 1);

        // Flush mid-division at cnt = 10.
        @(posedge clk);
        #1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        check("annul_stall_drop", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("annul_no_ready", {63'd0, ready_o}, 64'd0);
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 0);

        // Asynchronous reset at cnt = 20.
        @(posedge clk);
        #1;
        opdata1_i = 32'd5000;
        opdata2_i = 32'd13;
        start_i   = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_div(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34, 0);

        // Held start past ready must not restart.
        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 3);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
